// File: rtl/systolic_array_8x8.sv
// Output-stationary 8x8 systolic multiply-accumulate array.
// A flows left-to-right, B flows top-to-bottom, each PE accumulates a*b in place.
module systolic_array_8x8 #(
  parameter int unsigned data_width = 8,
  parameter int unsigned acc_width  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [8*data_width-1:0]         a_in_flat,
  input  logic [8*data_width-1:0]         b_in_flat,
  output logic [8*data_width-1:0]         a_out_flat,
  output logic [8*data_width-1:0]         b_out_flat,
  output logic [64*acc_width-1:0]         c_out_flat,
  output logic                            locked
);

  localparam int unsigned n          = 8;
  localparam int unsigned prod_width = 2 * data_width;

  logic [2:0]            lock_cnt;
  logic                  adv;

  logic [data_width-1:0] a_reg [n][n];
  logic [data_width-1:0] b_reg [n][n];
  logic [acc_width-1:0]  acc   [n][n];

  logic [data_width-1:0] a_src [n][n];
  logic [data_width-1:0] b_src [n][n];
  logic [prod_width-1:0] prod  [n][n];

  assign adv = en & locked & ~rst;

  // Lock after four consecutive non-reset edges; sticky until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt <= 3'd0;
      locked   <= 1'b0;
    end else if (!locked) begin
      lock_cnt <= lock_cnt + 3'd1;
      if (lock_cnt == 3'd3) locked <= 1'b1;
    end
  end

  // Operand routing: edge PEs take the external lanes, inner PEs take the neighbour register.
  always_comb begin
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned j = 0; j < n; j++) begin
        a_src[i][j] = '0;
        b_src[i][j] = '0;
        prod[i][j]  = '0;
      end
    end
    for (int unsigned i = 0; i < n; i++) begin
      a_src[i][0] = a_in_flat[i*data_width +: data_width];
      b_src[0][i] = b_in_flat[i*data_width +: data_width];
      for (int unsigned j = 1; j < n; j++) begin
        a_src[i][j] = a_reg[i][j-1];
        b_src[j][i] = b_reg[j-1][i];
      end
    end
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned j = 0; j < n; j++) begin
        prod[i][j] = prod_width'(a_src[i][j]) * prod_width'(b_src[i][j]);
      end
    end
  end

  // PE state: reset clears everything, otherwise advance only when adv.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < n; i++) begin
        for (int unsigned j = 0; j < n; j++) begin
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
          acc[i][j]   <= '0;
        end
      end
    end else if (adv) begin
      for (int unsigned i = 0; i < n; i++) begin
        for (int unsigned j = 0; j < n; j++) begin
          a_reg[i][j] <= a_src[i][j];
          b_reg[i][j] <= b_src[i][j];
          acc[i][j]   <= acc[i][j] + acc_width'(prod[i][j]);
        end
      end
    end
  end

  // Outputs are the PE registers themselves, flattened.
  always_comb begin
    a_out_flat = '0;
    b_out_flat = '0;
    c_out_flat = '0;
    for (int unsigned i = 0; i < n; i++) begin
      a_out_flat[i*data_width +: data_width] = a_reg[i][n-1];
      b_out_flat[i*data_width +: data_width] = b_reg[n-1][i];
      for (int unsigned j = 0; j < n; j++) begin
        c_out_flat[(i*n+j)*acc_width +: acc_width] = acc[i][j];
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_8x8.sv
// Directed bench for systolic_array_8x8: lock sequence, single product, skewed 8x8 matmul,
// enable hold, mid-feed reset and 16-bit accumulator wrap.
module tb_systolic_array_8x8;

  localparam int unsigned dw  = 8;
  localparam int unsigned n   = 8;
  localparam int unsigned aw  = 32;
  localparam int unsigned aw2 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en, locked;
  logic [n*dw-1:0]   a_in, b_in, a_out, b_out;
  logic [n*n*aw-1:0] c_out;

  logic               rst2, en2, locked2;
  logic [n*dw-1:0]    a2_in, b2_in, a2_out, b2_out;
  logic [n*n*aw2-1:0] c2_out;

  systolic_array_8x8 #(.data_width(dw), .acc_width(aw)) dut (
    .clk(clk), .rst(rst), .en(en), .a_in_flat(a_in), .b_in_flat(b_in),
    .a_out_flat(a_out), .b_out_flat(b_out), .c_out_flat(c_out), .locked(locked)
  );

  systolic_array_8x8 #(.data_width(dw), .acc_width(aw2)) dut16 (
    .clk(clk), .rst(rst2), .en(en2), .a_in_flat(a2_in), .b_in_flat(b2_in),
    .a_out_flat(a2_out), .b_out_flat(b2_out), .c_out_flat(c2_out), .locked(locked2)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int     i;
    int     j;
    longint exp;
  } cvec_t;

  cvec_t cvecs[6];

  function automatic longint c_at(input int i, input int j);
    return longint'(c_out[(i*n+j)*aw +: aw]);
  endfunction

  function automatic longint c2_at(input int i, input int j);
    return longint'(c2_out[(i*n+j)*aw2 +: aw2]);
  endfunction

  // Reference matmul for A[i][k]=8i+k+1, B[k][j]=8j+k+1.
  function automatic longint model_c(input int i, input int j);
    longint s = 0;
    for (int k = 0; k < 8; k++) s += longint'((8*i+k+1) * (8*j+k+1));
    return s;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [n*dw-1:0] a, input logic [n*dw-1:0] b);
    a_in = a;
    b_in = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse reset, then release and optionally check the lock sequence.
  task automatic reset_and_lock(input bit do_check, input logic [n*dw-1:0] filler);
    rst = 1'b1;
    step('0, '0);
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step(filler, filler);
      if (do_check) check($sformatf("locked_edge%0d", e), longint'(locked), (e == 4) ? 1 : 0);
    end
  endtask

  // Drive the skewed A/B feed for the given number of cycles (B=A^T makes lanes identical).
  task automatic feed_skewed(input int cycles);
    logic [n*dw-1:0] v;
    for (int t = 0; t < cycles; t++) begin
      v = '0;
      for (int i = 0; i < 8; i++) begin
        if (t - i >= 0 && t - i < 8) v[i*dw +: dw] = dw'(8*i + (t - i) + 1);
      end
      step(v, v);
    end
  endtask

  task automatic check_all_model(input string tag);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        check($sformatf("%s_c%0d%0d", tag, i, j), c_at(i, j), model_c(i, j));
  endtask

  initial begin
    logic [n*dw-1:0] v2;
    cvecs[0] = '{0, 0, 204};
    cvecs[1] = '{0, 7, 2220};
    cvecs[2] = '{7, 0, 2220};
    cvecs[3] = '{7, 7, 29324};
    cvecs[4] = '{3, 4, 8364};
    cvecs[5] = '{1, 2, 2092};

    rst = 1'b1; en = 1'b1; a_in = '0; b_in = '0;
    rst2 = 1'b1; en2 = 1'b1; a2_in = '0; b2_in = '0;
    @(negedge clk);
    step('0, '0);

    // Reset state
    check("rst_locked", longint'(locked), 0);
    check("rst_a_out", longint'(a_out), 0);
    check("rst_b_out", longint'(b_out), 0);
    check("rst_c_out_zero", longint'(c_out != '0), 0);

    // Lock sequence with en held high
    reset_and_lock(1'b1, '0);
    check("post_lock_c_zero", longint'(c_out != '0), 0);

    // Single product and 8-edge pass-through latency
    step(64'd3, 64'd5);
    for (int e = 1; e <= 9; e++) begin
      check($sformatf("a_out0_e%0d", e), longint'(a_out[dw-1:0]), (e == 8) ? 3 : 0);
      check($sformatf("b_out0_e%0d", e), longint'(b_out[dw-1:0]), (e == 8) ? 5 : 0);
      if (e < 9) step('0, '0);
    end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        check($sformatf("single_c%0d%0d", i, j), c_at(i, j), (i == 0 && j == 0) ? 15 : 0);

    // Full skewed matmul
    reset_and_lock(1'b0, '0);
    feed_skewed(15);
    for (int t = 0; t < 16; t++) step('0, '0);
    for (int v = 0; v < 6; v++)
      check($sformatf("matmul_c%0d%0d", cvecs[v].i, cvecs[v].j),
            c_at(cvecs[v].i, cvecs[v].j), cvecs[v].exp);
    check_all_model("matmul");

    // Enable low: state holds while inputs toggle
    en = 1'b0;
    for (int t = 0; t < 5; t++) begin
      step({8{8'hA5 ^ 8'(t)}}, {8{8'h3C + 8'(t)}});
      check($sformatf("hold_c00_t%0d", t), c_at(0, 0), 204);
      check($sformatf("hold_c77_t%0d", t), c_at(7, 7), 29324);
      check($sformatf("hold_a_out_t%0d", t), longint'(a_out), 0);
      check($sformatf("hold_b_out_t%0d", t), longint'(b_out), 0);
    end
    en = 1'b1;
    step(64'd3, 64'd5);
    for (int t = 0; t < 9; t++) step('0, '0);
    check("resume_c00", c_at(0, 0), 219);
    check("resume_c01", c_at(0, 1), model_c(0, 1));
    check("resume_c77", c_at(7, 7), 29324);

    // Reset mid-feed discards partial sums and drops locked
    reset_and_lock(1'b0, '0);
    feed_skewed(6);
    rst = 1'b1;
    step({8{8'h11}}, {8{8'h22}});
    check("midrst_c_zero", longint'(c_out != '0), 0);
    check("midrst_locked", longint'(locked), 0);
    check("midrst_a_out", longint'(a_out), 0);
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step({8{8'h11}}, {8{8'h22}});
      check($sformatf("relock_edge%0d", e), longint'(locked), (e == 4) ? 1 : 0);
    end
    check("relock_c_zero", longint'(c_out != '0), 0);
    feed_skewed(15);
    for (int t = 0; t < 16; t++) step('0, '0);
    check("recover_c00", c_at(0, 0), 204);
    check("recover_c77", c_at(7, 7), 29324);

    // 16-bit accumulator wrap on the second instance
    rst2 = 1'b0;
    for (int e = 0; e < 4; e++) step('0, '0);
    check("w16_locked", longint'(locked2), 1);
    for (int t = 0; t < 3; t++) begin
      v2 = '0;
      if (t <= 1) v2[0*dw +: dw] = 8'd255;
      if (t >= 1) v2[1*dw +: dw] = 8'd255;
      a2_in = v2;
      b2_in = v2;
      step('0, '0);
    end
    a2_in = '0;
    b2_in = '0;
    for (int t = 0; t < 20; t++) step('0, '0);
    check("w16_c00", c2_at(0, 0), 64514);
    check("w16_c01", c2_at(0, 1), 64514);
    check("w16_c10", c2_at(1, 0), 64514);
    check("w16_c11", c2_at(1, 1), 64514);
    check("w16_c02", c2_at(0, 2), 0);
    check("w16_c20", c2_at(2, 0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/systolic_array_8x8.md
SYSTOLIC_ARRAY_8X8 -- requirements
Module: systolic_array_8x8

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clock or asynchronous reset.
REQ-002 Parameter data_width, default 8: width of each A/B operand lane.
REQ-003 Parameter acc_width, default 32 (4*data_width): width of each accumulator C element.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 en  input  1  global advance enable.
REQ-007 a_in_flat  input  8*data_width  lane i, bits [i*data_width +: data_width], feeds row i from the left.
REQ-008 b_in_flat  input  8*data_width  lane j feeds column j from the top.
REQ-009 a_out_flat  output  8*data_width  lane i is the A value leaving row i at column 7.
REQ-010 b_out_flat  output  8*data_width  lane j is the B value leaving column j at row 7.
REQ-011 c_out_flat  output  64*acc_width  C[i][j] is at bits [(i*8+j)*acc_width +: acc_width].
REQ-012 locked  output  1  array ready; high when the array accepts data.

Function
REQ-013 The array SHALL be an output-stationary 8x8 grid of PEs; PE(i,j) holds a_reg, b_reg and acc.
REQ-014 PE(i,0) SHALL take a from a_in_flat lane i; PE(i,j>0) takes a_reg of PE(i,j-1).
REQ-015 PE(0,j) SHALL take b from b_in_flat lane j; PE(i>0,j) takes b_reg of PE(i-1,j).
REQ-016 Each PE SHALL update a_reg, b_reg and acc on every rising edge with adv = en && locked && !rst. The updates are: a_reg<=a, b_reg<=b, acc<=acc+a*b.
REQ-017 When adv is 0, all PE state SHALL hold.
REQ-018 Multiplication SHALL be unsigned, data_width x data_width to 2*data_width. The product is zero-extended, and accumulation wraps modulo 2^acc_width.
REQ-019 c_out_flat SHALL expose acc registers directly, with no extra output stage.
REQ-020 a_out_flat lane i SHALL equal a_reg of PE(i,7), and b_out_flat lane j SHALL equal b_reg of PE(7,j). A value driven at cycle n emerges after 8 advancing edges.
REQ-021 Data alignment SHALL be the caller's job. For C=A*B, drive A[i][k] on lane i and B[k][j] on lane j at cycle k+i and k+j respectively; other cycles carry 0.
REQ-022 Zero inputs SHALL contribute nothing, so gaps and bubbles are harmless.
REQ-023 locked SHALL go high after 4 consecutive clocks with rst low. The count uses a 3-bit counter, independent of en.
REQ-024 locked SHALL stay high until the next reset.

Reset
REQ-025 While rst=1 at a clock edge, all a_reg, b_reg, acc, the lock counter and locked SHALL become 0.
REQ-026 Consequently a_out_flat, b_out_flat and c_out_flat SHALL read 0 after a reset edge.
REQ-027 Reset asserted mid-computation SHALL discard all partial sums in that same edge, and rst SHALL have priority over en.
REQ-028 No reset SHALL be needed between computations other than to clear C; accumulation otherwise continues.

Verification
REQ-029 Reset release with en=1: all outputs read 0, locked=0 for the first 3 edges, and locked=1 after the 4th edge.
REQ-030 After locked, drive lane0 a=3 and b=5 for one cycle, then zeros: C[0][0]=15 and all other C=0. a_out lane0=3 and b_out lane0=5 appear exactly 8 edges after injection.
REQ-031 Skewed feed of A[i][k]=8i+k+1 and B=A^T (B[k][j]=8j+k+1), one cycle per step, then ≥16 zero cycles: C[i][j]=512ij+288(i+j)+204. Checkpoints: C[0][0]=204, C[0][7]=2220, C[7][7]=29324.
REQ-032 Hold en=0 for 5 cycles while nonzero inputs toggle: all C, a_out and b_out stay unchanged. Then en=1 resumes normal operation.
REQ-033 Instance with acc_width=16: lane0 a=b=255 for two consecutive cycles gives C[0][0]=64514 (wrap), and C[0][1] and C[1][0] are nonzero per skew.
REQ-034 Assert rst for one cycle mid-feed of REQ-031: all C read 0 next cycle and locked=0. locked returns after 4 edges.
